// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: 16x oversampling, 2-flop input synchroniser, 3-sample
// majority vote per bit, false-start rejection and break handling after a bad stop bit.
module uart_rx_deserializer #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic       rxReady,
  output logic [7:0] rxData,
  output logic       rxFramingError,
  output logic       rxBusy
);

  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int PW  = $clog2(DIV + 1);

  if (DIV < 1) begin : g_div_check
    $error("uart_rx_deserializer: CLK_HZ must be at least 16*BAUD");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      s_q, s_d;
  logic [1:0]      smp_q, smp_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            ready_q, ready_d;
  logic            ferr_q, ferr_d;
  logic [7:0]      data_q, data_d;

  logic rxs;
  logic tick;
  logic vote;
  logic vote_valid;
  logic last_tick;
  logic clear_cnt;

  assign rxs        = sync_q[1];
  assign tick       = (presc_q == PW'(DIV - 1));
  assign vote       = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
  assign vote_valid = tick && (s_q == 4'd9);
  assign last_tick  = tick && (s_q == 4'd15);
  assign clear_cnt  = (state_q == ST_IDLE) && !rxs;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: non-blocking so every flop in the block samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Datapath registers: synchroniser, counters, shift register, output strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b11;
      presc_q <= '0;
      s_q     <= 4'd0;
      smp_q   <= 2'b00;
      idx_q   <= 3'd0;
      // NOTE: the shift register is reset too, so a mid-frame reset cannot leak partial bits.
      shreg_q <= 8'h00;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      sync_q  <= sync_d;
      presc_q <= presc_d;
      s_q     <= s_d;
      smp_q   <= smp_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
    end
  end

  // Tick generation and mid-bit sample capture
  always_comb begin
    // NOTE: every variable gets a default first, so no path infers a latch.
    sync_d  = {sync_q[0], rxd};
    presc_d = tick ? '0 : presc_q + 1'b1;
    s_d     = tick ? s_q + 4'd1 : s_q;
    smp_d   = smp_q;
    if (tick && (s_q == 4'd7)) smp_d[0] = rxs;
    if (tick && (s_q == 4'd8)) smp_d[1] = rxs;
    if (clear_cnt) begin
      presc_d = '0;
      s_d     = 4'd0;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!rxs) state_d = ST_START;
      end
      ST_START: begin
        if (vote_valid && vote) begin
          state_d = ST_IDLE;
        end else if (last_tick) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (vote_valid) shreg_d[idx_q] = vote;
        if (last_tick) begin
          if (idx_q == 3'd7) state_d = ST_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      ST_STOP: begin
        // Leave at the mid-stop vote so a start bit in the stop bit's second half is seen.
        if (vote_valid) state_d = vote ? ST_IDLE : ST_BREAK;
      end
      ST_BREAK: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready_d = (state_q == ST_STOP) && vote_valid && vote;
    ferr_d  = (state_q == ST_STOP) && vote_valid && !vote;
    data_d  = ready_d ? shreg_q : data_q;
  end

  assign rxReady        = ready_q;
  assign rxFramingError = ferr_q;
  assign rxData         = data_q;
  assign rxBusy         = (state_q != ST_IDLE);

endmodule
